// File: rtl/cache_mem_arbiter.sv
// Purpose: shares one main-memory line port between icache refill and dcache refill/writeback.
// Latency: request seen at edge N drives mem_req_o from cycle N+1; acks are combinational from mem_ack_i.
// Backpressure: requesters hold req until ack; the grant is held until mem ack or an accepted icache kill.
module cache_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // icache refill side
   input  logic                  ic_req_i,
   input  logic                  ic_kill_i,
   input  logic [ADDR_WIDTH-1:0] ic_addr_i,
   output logic                  ic_ack_o,
   output logic [LINE_WIDTH-1:0] ic_rdata_o,
   // dcache refill / writeback side
   input  logic                  dc_req_i,
   input  logic                  dc_we_i,
   input  logic [ADDR_WIDTH-1:0] dc_addr_i,
   input  logic [LINE_WIDTH-1:0] dc_wdata_i,
   output logic                  dc_ack_o,
   output logic [LINE_WIDTH-1:0] dc_rdata_o,
   // memory line port
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic                  mem_kill_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [LINE_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_ack_i,
   input  logic [LINE_WIDTH-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_IC = 2'd1,
      GNT_DC = 2'd2
   } state_t;

   state_t state;
   logic   last_grant_dc;   // 0 = icache had the last grant, 1 = dcache
   logic   ic_vld;
   logic   grant_dc;
   logic   grant_ic;

   // Grant selection in IDLE: a killed icache request is not a request; ties go opposite to last grant
   always_comb begin
      ic_vld   = ic_req_i & ~ic_kill_i;
      grant_dc = dc_req_i & (~ic_vld | ~last_grant_dc);
      grant_ic = ic_vld & ~grant_dc;
   end

   // Acks are gated by the owning grant state so a stray mem ack never leaks to the other side
   always_comb begin
      ic_ack_o   = (state == GNT_IC) & mem_ack_i;
      dc_ack_o   = (state == GNT_DC) & mem_ack_i;
      ic_rdata_o = mem_rdata_i;
      dc_rdata_o = mem_rdata_i;
   end

   // Arbitration FSM with registered memory-side outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         last_grant_dc <= 1'b0;
         mem_req_o     <= 1'b0;
         mem_we_o      <= 1'b0;
         mem_kill_o    <= 1'b0;
         mem_addr_o    <= '0;
         mem_wdata_o   <= '0;
      end else begin
         mem_kill_o <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_dc) begin
                  state         <= GNT_DC;
                  last_grant_dc <= 1'b1;
                  mem_req_o     <= 1'b1;
                  mem_we_o      <= dc_we_i;
                  mem_addr_o    <= dc_addr_i;
                  mem_wdata_o   <= dc_wdata_i;
               end else if (grant_ic) begin
                  state         <= GNT_IC;
                  last_grant_dc <= 1'b0;
                  mem_req_o     <= 1'b1;
                  mem_we_o      <= 1'b0;
                  mem_addr_o    <= ic_addr_i;
               end
            end
            GNT_IC: begin
               // An ack in the same cycle as a kill wins: the transfer is complete, nothing to abort
               if (mem_ack_i) begin
                  state     <= IDLE;
                  mem_req_o <= 1'b0;
               end else if (ic_kill_i | ~ic_req_i) begin
                  state      <= IDLE;
                  mem_req_o  <= 1'b0;
                  mem_kill_o <= 1'b1;
               end
            end
            GNT_DC: begin
               if (mem_ack_i) begin
                  state     <= IDLE;
                  mem_req_o <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               mem_req_o <= 1'b0;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   // Protocol and internal consistency checks
   a_one_ack: assert property (@(posedge clk) disable iff (!rst_n) !(ic_ack_o && dc_ack_o));
   a_dc_hold: assert property (@(posedge clk) disable iff (!rst_n) (state == GNT_DC) |-> dc_req_i);
   a_kill_src: assert property (@(posedge clk) disable iff (!rst_n)
      mem_kill_o |-> ((state == IDLE) && ($past(state) == GNT_IC)));
   a_idle_req: assert property (@(posedge clk) disable iff (!rst_n) (state == IDLE) |-> !mem_req_o);
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Purpose: directed self-checking bench for cache_mem_arbiter.
// Latency: inputs driven 1 time unit after posedge, registered outputs checked 1 unit after the next posedge.
// Backpressure: requesters modelled as holding req until their ack.
module tb_cache_mem_arbiter;

   localparam int AW = 32;
   localparam int LW = 128;

   logic          clk;
   logic          rst_n;
   logic          ic_req, ic_kill, ic_ack;
   logic [AW-1:0] ic_addr;
   logic [LW-1:0] ic_rdata;
   logic          dc_req, dc_we, dc_ack;
   logic [AW-1:0] dc_addr;
   logic [LW-1:0] dc_wdata, dc_rdata;
   logic          mem_req, mem_we, mem_kill, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   localparam logic [LW-1:0] RD0 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [LW-1:0] WD0 = 128'hDEADBEEF_CAFEF00D_11223344_55667788;
   localparam logic [LW-1:0] RD1 = 128'hA5A5A5A5_5A5A5A5A_00FF00FF_FF00FF00;

   cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ic_req_i    (ic_req),
      .ic_kill_i   (ic_kill),
      .ic_addr_i   (ic_addr),
      .ic_ack_o    (ic_ack),
      .ic_rdata_o  (ic_rdata),
      .dc_req_i    (dc_req),
      .dc_we_i     (dc_we),
      .dc_addr_i   (dc_addr),
      .dc_wdata_i  (dc_wdata),
      .dc_ack_o    (dc_ack),
      .dc_rdata_o  (dc_rdata),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_kill_o  (mem_kill),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_ack_i   (mem_ack),
      .mem_rdata_i (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ic_req = 0; ic_kill = 0; ic_addr = '0;
      dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
      mem_ack = 0; mem_rdata = '0;
   endtask

   initial begin
      clear_inputs();
      rst_n = 0;
      tick(); tick();
      // reset state
      check("rst_mem_req",  mem_req,  0);
      check("rst_mem_we",   mem_we,   0);
      check("rst_mem_kill", mem_kill, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      mem_ack = 1; #1;
      check("rst_acks", {ic_ack, dc_ack}, 0);
      mem_ack = 0;
      @(negedge clk); rst_n = 1;
      tick();

      // ---- single icache read ----
      ic_req = 1; ic_addr = 32'h8000_0040;
      tick();                                   // cycle 1
      check("t1_mem_req",  mem_req,  1);
      check("t1_mem_we",   mem_we,   0);
      check("t1_mem_addr", mem_addr, 32'h8000_0040);
      tick(); tick();                           // cycle 3
      check("t1_no_ack_wait", ic_ack, 0);
      tick();                                   // cycle 4
      mem_ack = 1; mem_rdata = RD0; #1;
      check("t1_ic_ack",   ic_ack,   1);
      check("t1_ic_rdata", ic_rdata, RD0);
      check("t1_dc_ack",   dc_ack,   0);
      tick();                                   // cycle 5
      mem_ack = 0; ic_req = 0;
      check("t1_req_drop", mem_req, 0);
      check("t1_no_kill",  mem_kill, 0);
      tick();

      // ---- contention: last_grant is IC, so dcache wins the tie ----
      ic_req = 1; ic_addr = 32'h8000_0080;
      dc_req = 1; dc_we = 1; dc_addr = 32'h8000_1000; dc_wdata = WD0;
      tick();
      check("t2_dc_first_we",    mem_we,    1);
      check("t2_dc_first_addr",  mem_addr,  32'h8000_1000);
      check("t2_dc_first_wdata", mem_wdata, WD0);
      tick();
      mem_ack = 1; mem_rdata = RD1; #1;
      check("t2_dc_ack", {ic_ack, dc_ack}, 2'b01);
      tick();
      // dcache keeps requesting (new read) across its ack: tie in IDLE goes to icache
      mem_ack = 0; dc_we = 0; dc_addr = 32'h8000_2000;
      check("t2_idle_gap", mem_req, 0);
      check("t2_addr_hold", mem_addr, 32'h8000_1000);
      tick();
      check("t2_ic_second_req",  mem_req,  1);
      check("t2_ic_second_addr", mem_addr, 32'h8000_0080);
      check("t2_ic_second_we",   mem_we,   0);
      mem_ack = 1; mem_rdata = RD1; #1;
      check("t2_ic_ack", {ic_ack, dc_ack}, 2'b10);
      check("t2_ic_rdata", ic_rdata, RD1);
      tick();
      mem_ack = 0; ic_req = 0;
      tick();
      check("t2_dc_third_addr", mem_addr, 32'h8000_2000);
      check("t2_dc_third_we",   mem_we,   0);
      mem_ack = 1; #1;
      check("t2_dc_ack2", dc_ack, 1);
      tick();
      clear_inputs();
      tick();

      // ---- kill mid-flight ----
      ic_req = 1; ic_addr = 32'h8000_0100;
      tick();                                   // cycle 1
      check("t3_grant", mem_req, 1);
      tick(); tick();                           // cycle 3
      ic_kill = 1; #1;
      check("t3_no_ack", ic_ack, 0);
      tick();                                   // cycle 4
      ic_kill = 0; ic_req = 0;
      check("t3_req_drop", mem_req, 0);
      check("t3_kill",     mem_kill, 1);
      tick();                                   // cycle 5
      check("t3_kill_pulse", mem_kill, 0);
      mem_ack = 1; mem_rdata = RD0; #1;
      check("t3_idle_ack_ignored", {ic_ack, dc_ack}, 0);
      tick();
      mem_ack = 0;
      check("t3_idle_stays", mem_req, 0);
      tick();

      // ---- kill coincident with ack ----
      ic_req = 1; ic_addr = 32'h8000_0140;
      tick(); tick(); tick();                   // cycle 3
      ic_kill = 1; mem_ack = 1; mem_rdata = RD1; #1;
      check("t4_ack_wins", ic_ack, 1);
      tick();
      clear_inputs();
      check("t4_no_kill", mem_kill, 0);
      check("t4_req_drop", mem_req, 0);
      tick();
      check("t4_no_kill_late", mem_kill, 0);

      // ---- back-to-back dcache ----
      dc_req = 1; dc_we = 0; dc_addr = 32'h8000_3000;
      tick();
      check("t5_grant_a", mem_addr, 32'h8000_3000);
      mem_ack = 1; #1;
      check("t5_ack_a", dc_ack, 1);
      tick();
      mem_ack = 0; dc_addr = 32'h8000_3040;
      check("t5_gap_req", mem_req, 0);
      check("t5_gap_addr_hold", mem_addr, 32'h8000_3000);
      tick();
      check("t5_regrant_req",  mem_req,  1);
      check("t5_regrant_addr", mem_addr, 32'h8000_3040);
      mem_ack = 1; #1;
      tick();
      clear_inputs();
      tick();

      // ---- async reset during GNT_DC ----
      dc_req = 1; dc_we = 1; dc_addr = 32'h8000_4000; dc_wdata = WD0;
      ic_req = 1; ic_addr = 32'h8000_0200;      // icache alone? no: tie after t5 (last=DC) -> icache
      tick();
      check("t6_tie_to_ic", mem_addr, 32'h8000_0200);
      mem_ack = 1; #1;
      tick();
      mem_ack = 0; ic_req = 0;
      tick();
      check("t6_dc_grant_we", mem_we, 1);
      mem_ack = 1; #1;
      check("t6_dc_ack_pre", dc_ack, 1);
      #2 rst_n = 0; #1;
      check("t6_rst_req",  mem_req, 0);
      check("t6_rst_we",   mem_we,  0);
      check("t6_rst_acks", {ic_ack, dc_ack}, 0);
      clear_inputs();
      @(negedge clk); rst_n = 1;
      tick();
      ic_req = 1; ic_addr = 32'h8000_0300;
      dc_req = 1; dc_we = 0; dc_addr = 32'h8000_5000;
      tick();
      check("t6_post_rst_tie_dc", mem_addr, 32'h8000_5000);
      mem_ack = 1; #1;
      check("t6_post_rst_dc_ack", {ic_ack, dc_ack}, 2'b01);
      tick();
      clear_inputs();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
